line_beat_sequencer: RTL and testbench
======================================

LINE_BEAT_SEQUENCER -- requirements
Module: line_beat_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- BUS_WIDTH, 32, external data bus width in bits; legal values 16, 32, 64, 128.
- DATA_WIDTH, 8, addressable unit of external memory in bits; legal values 8, 16, 32, 64; must not exceed BUS_WIDTH.
- BEATS, 128/BUS_WIDTH, derived beat count per line; not overridable.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- line_ren  in  1  read-line request from L1.
- line_wen  in  1  write-line (writeback) request from L1.
- line_addr  in  32  byte address inside the target line.
- line_wdata  in  128  line to write; MSB-first.
- line_rdata  out  128  assembled read line.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- bus_valid  out  1  beat request valid.
- bus_ready  in  1  slave accepts the beat.
- bus_we  out  1  beat is a write.
- bus_addr  out  32  beat address in DATA_WIDTH units.
- bus_wdata  out  BUS_WIDTH  write beat data.
- bus_rvalid  in  1  read beat data valid.
- bus_rdata  in  BUS_WIDTH  read beat data.
REQ-003 Clock is one; reset is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have four states: IDLE, REQ, WAIT_R, DONE.
REQ-005 In IDLE, a request SHALL be sampled on each rising edge when line_wen or line_ren is high.
- On a sampled request, the block latches line_addr, line_wdata and the operation type.
- It clears the beat counter k to 0 and moves to REQ.
REQ-006 If line_wen and line_ren are both high in IDLE, the request SHALL be a write; the read is dropped.
REQ-007 Request inputs SHALL be ignored in REQ, WAIT_R and DONE.
REQ-008 Beat addressing and data:
- bus_addr = line_addr[31:4]*(128/DATA_WIDTH) + k*(BUS_WIDTH/DATA_WIDTH), truncated to 32 bits.
- Beat k covers line bits [127-k*BUS_WIDTH : 128-(k+1)*BUS_WIDTH].
REQ-009 In REQ, bus_valid SHALL be 1, and bus_we SHALL equal the latched type.
- bus_addr and bus_wdata stay stable until the cycle in which bus_valid and bus_ready are both high.
REQ-010 On a REQ write handshake: if k = BEATS-1, the FSM goes to DONE; otherwise k increments and it stays in REQ.
REQ-011 On a REQ read handshake, the FSM SHALL go to WAIT_R.
REQ-012 In WAIT_R:
- bus_valid = 0.
- When bus_rvalid = 1, bus_rdata is captured into slice k of line_rdata.
- Then the FSM goes to DONE if k = BEATS-1; otherwise k increments and it returns to REQ.
- bus_rvalid is ignored outside WAIT_R.
REQ-013 busy SHALL be 1 exactly in REQ and WAIT_R.
REQ-014 done SHALL be 1 exactly in DONE; DONE always returns to IDLE on the next edge.
REQ-015 line_rdata SHALL hold its value except during slice captures; after a write it keeps the last read line.
REQ-016 With no stalls:
- A write SHALL take BEATS busy cycles.
- A read with rvalid one cycle after accept SHALL take 2*BEATS busy cycles.
- The first bus_valid appears the cycle after the request is sampled.
REQ-017 There SHALL be no timeout; an indefinitely low bus_ready or bus_rvalid holds the FSM in place.

Reset
REQ-018 While reset is low, the block SHALL immediately (asynchronously) force:
- state IDLE, k = 0.
- busy, done, bus_valid, bus_we = 0.
- bus_addr = 0, bus_wdata = 0, line_rdata = 0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer.
- No done pulse is produced.
- Partially captured line_rdata is cleared.
- No request is remembered.
REQ-020 After reset deasserts, the first request SHALL be sampled no earlier than the first rising edge with reset high.

Verification
REQ-021 Write burst, BUS_WIDTH=32, DATA_WIDTH=8, bus_ready=1, line_addr=0x0000_1234, line_wdata=0x00112233_44556677_8899AABB_CCDDEEFF:
- Beats SHALL be addr 0x1230/0x1234/0x1238/0x123C with data 0x00112233/0x44556677/0x8899AABB/0xCCDDEEFF.
- busy high 4 cycles, then done for 1 cycle.
REQ-022 Read burst, same parameters, slave returns 0xA0000000+k one cycle after each accept:
- line_rdata = 0xA0000000_A0000001_A0000002_A0000003.
- busy high 8 cycles, then done.
REQ-023 Stall: bus_ready held low for 5 cycles on beat 2 of a write:
- bus_addr and bus_wdata stay constant throughout the stall.
- Total busy = 9 cycles.
REQ-024 Both line_ren and line_wen high at 0x40 -> bus_we = 1 on all beats, and line_rdata is unchanged.
REQ-025 Reset low during WAIT_R of beat 1 -> all outputs are 0 in that same cycle, with no done pulse.
- The next read then completes normally.
REQ-026 BUS_WIDTH=128, DATA_WIDTH=8, read at 0x0000_00F7 -> one beat at bus_addr 0xF0, 2 busy cycles.

Source files
------------

// File: rtl/line_beat_sequencer.sv
// line_beat_sequencer: moves one 128-bit L1 line to or from external memory as
// BEATS bus beats, using a valid/ready request channel and an rvalid return channel.
module line_beat_sequencer #(
    parameter  int BUS_WIDTH  = 32,
    parameter  int DATA_WIDTH = 8,
    localparam int BEATS      = 128 / BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 line_ren,
    input  logic                 line_wen,
    input  logic [31:0]          line_addr,
    input  logic [127:0]         line_wdata,
    output logic [127:0]         line_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic                 bus_we,
    output logic [31:0]          bus_addr,
    output logic [BUS_WIDTH-1:0] bus_wdata,
    input  logic                 bus_rvalid,
    input  logic [BUS_WIDTH-1:0] bus_rdata
);

    // state  | meaning
    // IDLE   | waiting for line_wen / line_ren
    // REQ    | beat k offered on the bus, waiting for bus_ready
    // WAIT_R | read beat k accepted, waiting for bus_rvalid
    // DONE   | one-cycle completion pulse, back to IDLE

    localparam int              K_W        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0]     LINE_UNITS = 32'(128 / DATA_WIDTH);
    localparam logic [31:0]     BEAT_UNITS = 32'(BUS_WIDTH / DATA_WIDTH);
    localparam logic [K_W-1:0]  LAST_K     = K_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic           we_q, we_d;
    logic [27:0]    line_q, line_d;
    logic [127:0]   wdata_q, wdata_d;
    logic [127:0]   rdata_q, rdata_d;

    // Byte offset inside the line does not affect beat addressing.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^line_addr[3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            we_q    <= 1'b0;
            line_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            we_q    <= we_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        we_d    = we_q;
        line_d  = line_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (line_wen || line_ren) begin
                    // A simultaneous read and write request resolves to the write.
                    we_d    = line_wen;
                    line_d  = line_addr[31:4];
                    wdata_d = line_wdata;
                    k_d     = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus_ready) begin
                    if (!we_q) begin
                        state_d = WAIT_R;
                    end else if (k_q == LAST_K) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            WAIT_R: begin
                if (bus_rvalid) begin
                    for (int i = 0; i < BEATS; i++) begin
                        if (k_q == K_W'(i)) begin
                            rdata_d[127 - i*BUS_WIDTH -: BUS_WIDTH] = bus_rdata;
                        end
                    end
                    if (k_q == LAST_K) begin
                        state_d = DONE;
                    end else begin
                        k_d     = k_q + K_W'(1);
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic [31:0] line_base;
    logic [31:0] beat_off;

    always_comb begin
        bus_valid  = (state_q == REQ);
        bus_we     = (state_q == REQ) && we_q;
        busy       = (state_q == REQ) || (state_q == WAIT_R);
        done       = (state_q == DONE);
        line_rdata = rdata_q;
        line_base  = {4'b0000, line_q} * LINE_UNITS;
        beat_off   = {{(32-K_W){1'b0}}, k_q} * BEAT_UNITS;
        bus_addr   = line_base + beat_off;
        bus_wdata  = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (k_q == K_W'(i)) begin
                bus_wdata = wdata_q[127 - i*BUS_WIDTH -: BUS_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_line_beat_sequencer.sv
// Bench for line_beat_sequencer: a 32-bit-bus and a 128-bit-bus instance driven by a
// cycle-level slave/requester model that predicts every beat from the line rules.
module tb_line_beat_sequencer;

    localparam int P_REQ  = 0;
    localparam int P_WAIT = 1;
    localparam int P_DONE = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         a_ren, a_wen, b_ren, b_wen;
    logic [31:0]  line_addr;
    logic [127:0] line_wdata;
    logic         bus_ready, bus_rvalid;
    logic [127:0] rdata_bus;

    logic [127:0] a_line_rdata, b_line_rdata;
    logic         a_busy, a_done, a_bus_valid, a_bus_we;
    logic         b_busy, b_done, b_bus_valid, b_bus_we;
    logic [31:0]  a_bus_addr, b_bus_addr;
    logic [31:0]  a_bus_wdata;
    logic [127:0] b_bus_wdata;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [127:0] exp_line [2];
    logic sel;

    always #5 clk = ~clk;

    line_beat_sequencer #(.BUS_WIDTH(32), .DATA_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .line_ren(a_ren), .line_wen(a_wen),
        .line_addr(line_addr), .line_wdata(line_wdata), .line_rdata(a_line_rdata),
        .busy(a_busy), .done(a_done), .bus_valid(a_bus_valid), .bus_ready(bus_ready),
        .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(rdata_bus[31:0])
    );

    line_beat_sequencer #(.BUS_WIDTH(128), .DATA_WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .line_ren(b_ren), .line_wen(b_wen),
        .line_addr(line_addr), .line_wdata(line_wdata), .line_rdata(b_line_rdata),
        .busy(b_busy), .done(b_done), .bus_valid(b_bus_valid), .bus_ready(bus_ready),
        .bus_we(b_bus_we), .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(rdata_bus)
    );

    logic         o_busy, o_done, o_valid, o_we;
    logic [31:0]  o_addr;
    logic [127:0] o_wdata, o_rdata;
    assign o_busy  = sel ? b_busy       : a_busy;
    assign o_done  = sel ? b_done       : a_done;
    assign o_valid = sel ? b_bus_valid  : a_bus_valid;
    assign o_we    = sel ? b_bus_we     : a_bus_we;
    assign o_addr  = sel ? b_bus_addr   : a_bus_addr;
    assign o_wdata = sel ? b_bus_wdata  : {96'b0, a_bus_wdata};
    assign o_rdata = sel ? b_line_rdata : a_line_rdata;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] slice_mask(input int bw);
        return (bw == 128) ? {128{1'b1}} : ((128'd1 << bw) - 128'd1);
    endfunction

    function automatic logic [127:0] get_slice(input logic [127:0] line, input int bw, input int k);
        return (line >> (128 - (k + 1) * bw)) & slice_mask(bw);
    endfunction

    function automatic logic [127:0] put_slice(input logic [127:0] line, input logic [127:0] v,
                                               input int bw, input int k);
        int sh;
        sh = 128 - (k + 1) * bw;
        return (line & ~(slice_mask(bw) << sh)) | ((v & slice_mask(bw)) << sh);
    endfunction

    // Line number times units-per-line plus beat offset, all in bytes.
    function automatic logic [31:0] exp_addr(input logic [31:0] a, input int bw, input int k);
        return (a >> 4) * 32'd16 + 32'(k * (bw / 8));
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_req(input int which, input logic w, input logic r);
        if (which == 0) begin
            a_wen = w;
            a_ren = r;
        end else begin
            b_wen = w;
            b_ren = r;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk_b({tag, "_busy"}, o_busy, 1'b0);
        chk_b({tag, "_done"}, o_done, 1'b0);
        chk_b({tag, "_valid"}, o_valid, 1'b0);
        chk_b({tag, "_we"}, o_we, 1'b0);
        chk_w({tag, "_addr"}, 128'(o_addr), 128'd0);
        chk_w({tag, "_wdata"}, o_wdata, 128'd0);
        chk_w({tag, "_rdata"}, o_rdata, 128'd0);
    endtask

    task automatic xfer(input int which, input logic wen, input logic ren,
                        input logic [31:0] a, input logic [127:0] wd,
                        input int stall_beat, input int stall_len, input bit fixed_rd,
                        input int max_dly, input bit rnd_ready, input int abort_beat,
                        output int busy_obs, output int busy_exp);
        int bw, beats, phase, k, stall_left, wait_left;
        bit is_we, finished;
        logic [127:0] rd;
        bw         = (which != 0) ? 128 : 32;
        beats      = 128 / bw;
        sel        = (which != 0);
        is_we      = wen;
        phase      = P_REQ;
        k          = 0;
        stall_left = stall_len;
        wait_left  = 0;
        finished   = 1'b0;
        busy_obs   = 0;
        busy_exp   = 0;
        @(negedge clk);
        set_req(which, wen, ren);
        line_addr  = a;
        line_wdata = wd;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(negedge clk);
            if (o_busy) busy_obs++;
            if (phase != P_DONE) busy_exp++;
            chk_b("busy", o_busy, phase != P_DONE);
            chk_b("done", o_done, phase == P_DONE);
            chk_b("bus_valid", o_valid, phase == P_REQ);
            line_addr  = $urandom();
            line_wdata = rnd128();
            bus_rvalid = 1'($urandom_range(0, 1));
            rdata_bus  = rnd128();
            bus_ready  = 1'($urandom_range(0, 1));
            set_req(which, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            case (phase)
                P_REQ: begin
                    chk_b("bus_we", o_we, is_we);
                    chk_w("bus_addr", 128'(o_addr), 128'(exp_addr(a, bw, k)));
                    if (is_we) chk_w("bus_wdata", o_wdata, get_slice(wd, bw, k));
                    if (k == stall_beat && stall_left > 0) begin
                        bus_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                    end
                    if (bus_ready) begin
                        if (!is_we) begin
                            phase     = P_WAIT;
                            wait_left = $urandom_range(0, max_dly);
                        end else if (k == beats - 1) begin
                            phase = P_DONE;
                        end else begin
                            k++;
                        end
                    end
                end
                P_WAIT: begin
                    if (k == abort_beat) begin
                        reset = 1'b0;
                        set_req(which, 1'b0, 1'b0);
                        bus_rvalid = 1'b0;
                        bus_ready  = 1'b0;
                        #1;
                        chk_zero("abort");
                        return;
                    end
                    if (wait_left == 0) begin
                        bus_rvalid = 1'b1;
                        rd = fixed_rd ? {96'b0, 32'hA000_0000 + 32'(k)} : rdata_bus;
                        rdata_bus = rd;
                        exp_line[which] = put_slice(exp_line[which], rd, bw, k);
                        if (k == beats - 1) begin
                            phase = P_DONE;
                        end else begin
                            k++;
                            phase = P_REQ;
                        end
                    end else begin
                        wait_left--;
                        bus_rvalid = 1'b0;
                    end
                end
                default: begin
                    chk_w("line_rdata", o_rdata, exp_line[which]);
                    set_req(which, 1'b0, 1'b0);
                    bus_ready  = 1'b0;
                    bus_rvalid = 1'b0;
                    finished   = 1'b1;
                end
            endcase
        end
        chk_b("completed", finished, 1'b1);
        @(negedge clk);
        chk_b("done_one_cycle", o_done, 1'b0);
        chk_b("idle_after_done", o_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int bo, be, op;
        reset      = 1'b0;
        a_ren      = 1'b0;
        a_wen      = 1'b0;
        b_ren      = 1'b0;
        b_wen      = 1'b0;
        line_addr  = '0;
        line_wdata = '0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        rdata_bus  = '0;
        sel        = 1'b0;
        exp_line[0] = '0;
        exp_line[1] = '0;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        chk_zero("reset_a");
        sel = 1'b1;
        chk_zero("reset_b");
        reset = 1'b1;

        xfer(0, 1'b1, 1'b0, 32'h0000_1234, 128'h00112233_44556677_8899AABB_CCDDEEFF,
             -1, 0, 1'b0, 0, 1'b0, -1, bo, be);
        chk_i("write_busy_cycles", bo, 4);

        xfer(0, 1'b0, 1'b1, 32'h0000_1234, 128'h0, -1, 0, 1'b1, 0, 1'b0, -1, bo, be);
        chk_i("read_busy_cycles", bo, 8);
        chk_w("read_line", a_line_rdata, 128'hA0000000_A0000001_A0000002_A0000003);

        xfer(0, 1'b1, 1'b0, 32'h0000_2000, 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE,
             2, 5, 1'b0, 0, 1'b0, -1, bo, be);
        chk_i("stall_busy_cycles", bo, 9);

        xfer(0, 1'b1, 1'b1, 32'h0000_0040, 128'h11111111_22222222_33333333_44444444,
             -1, 0, 1'b0, 0, 1'b0, -1, bo, be);
        chk_i("both_req_busy_cycles", bo, 4);
        chk_w("both_req_line_kept", a_line_rdata, 128'hA0000000_A0000001_A0000002_A0000003);

        xfer(0, 1'b0, 1'b1, 32'h0000_0300, 128'h0, -1, 0, 1'b1, 0, 1'b0, 1, bo, be);
        @(negedge clk);
        chk_b("abort_no_done", a_done, 1'b0);
        chk_b("abort_no_busy", a_busy, 1'b0);
        chk_w("abort_line_cleared", a_line_rdata, 128'h0);
        exp_line[0] = '0;
        exp_line[1] = '0;
        reset = 1'b1;
        xfer(0, 1'b0, 1'b1, 32'h0000_0300, 128'h0, -1, 0, 1'b1, 0, 1'b0, -1, bo, be);
        chk_i("post_abort_busy_cycles", bo, 8);
        chk_w("post_abort_line", a_line_rdata, 128'hA0000000_A0000001_A0000002_A0000003);

        xfer(1, 1'b0, 1'b1, 32'h0000_00F7, 128'h0, -1, 0, 1'b0, 0, 1'b0, -1, bo, be);
        chk_i("wide_read_busy_cycles", bo, 2);

        for (int n = 0; n < 24; n++) begin
            op = $urandom_range(0, 2);
            xfer($urandom_range(0, 1), 1'(op != 1), 1'(op != 0), $urandom(), rnd128(),
                 $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, 2, 1'b1, -1, bo, be);
            chk_i("random_busy_cycles", bo, be);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
